// File: rtl/intc_top_ctrl.sv
// -----------------------------------------------------------------------------
// intc_top_ctrl : four-source memory-mapped interrupt controller.
//   Latches rising edges of done[3:0] as pending interrupts. Arbitrates among
//   enabled pending sources, raises IRQ with the winner's ISR address, and
//   retires the winner on IACK.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   done[3:0]           per-source completion levels (edge detected)
//   IACK                interrupt acknowledge from host
//   input_addr[31:0]    register byte address (bits [5:2] decoded)
//   write_enable        register write strobe
//   write_data[31:0]    register write data
//   read_data[31:0]     combinational register read
//   IRQ                 registered interrupt request
//   isr_addr[31:0]      registered ISR address of the active interrupt
//
// Build option: INTC_ROUND_ROBIN_EN selects rotating priority. When it is
// undefined, priority is fixed with source 0 highest.
// -----------------------------------------------------------------------------
module intc_top_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  done,
  input  logic        IACK,
  input  logic [31:0] input_addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        IRQ,
  output logic [31:0] isr_addr
);

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_W   = 2;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_MASK = 4'h1;
  localparam logic [3:0] REG_PEND = 4'h2;
  localparam logic [3:0] REG_STAT = 4'h3;

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_gie;
  logic [NUM_SRC-1:0]       r_mask;
  logic [NUM_SRC-1:0]       r_pend;
  logic [NUM_SRC-1:0]       r_done_q;
  logic [DATA_W-1:0]        r_isr [NUM_SRC];
  logic [SEL_W-1:0]         r_sel, w_sel_nxt;
  logic                     r_irq, w_irq_nxt;
  logic [DATA_W-1:0]        r_isr_addr, w_isr_addr_nxt;

  logic [3:0]               w_idx;
  logic                     w_unused;
  logic                     w_wr_ctrl, w_wr_mask, w_wr_pend, w_wr_isr;
  logic                     w_gie_nxt;
  logic [NUM_SRC-1:0]       w_mask_nxt, w_pend_nxt, w_pend_set, w_pend_clr;
  logic [NUM_SRC-1:0]       w_cand, w_sel_oh, w_stat_src;
  logic [SEL_W-1:0]         w_win;
  logic                     w_ack, w_cancel;

  assign w_idx    = input_addr[5:2];
  assign w_unused = ^{input_addr[31:6], input_addr[1:0]};

  // Register write decode
  assign w_wr_ctrl = write_enable && (w_idx == REG_CTRL);
  assign w_wr_mask = write_enable && (w_idx == REG_MASK);
  assign w_wr_pend = write_enable && (w_idx == REG_PEND);
  assign w_wr_isr  = write_enable && (w_idx[3:2] == 2'b01);

  assign w_gie_nxt  = w_wr_ctrl ? write_data[0] : r_gie;
  assign w_mask_nxt = w_wr_mask ? write_data[NUM_SRC-1:0] : r_mask;

  // Pending update: a new edge overrides any clear in the same cycle
  assign w_sel_oh   = NUM_SRC'(4'b0001 << r_sel);
  assign w_ack      = IACK && (r_state == S_ACTIVE);
  assign w_pend_set = done & ~r_done_q;
  assign w_pend_clr = (w_wr_pend ? write_data[NUM_SRC-1:0] : '0) |
                      (w_ack ? w_sel_oh : '0);
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_pend_set;

  assign w_cand = r_pend & r_mask & {NUM_SRC{r_gie}};

  // Cancel looks at the values being written this cycle so IRQ drops at the
  // same edge the software change lands
  assign w_cancel = !(w_pend_nxt[r_sel] && w_mask_nxt[r_sel] && w_gie_nxt);

`ifdef INTC_ROUND_ROBIN_EN
  logic [SEL_W-1:0] r_last;

  // Rotating search from r_last+1; scanned backwards so the earliest wins
  always_comb begin
    w_win = '0;
    for (int i = int'(NUM_SRC); i >= 1; i--) begin
      if (w_cand[SEL_W'(r_last + SEL_W'(i))]) w_win = SEL_W'(r_last + SEL_W'(i));
    end
  end

  // Last-served pointer; reset value makes the first search start at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last <= SEL_W'(NUM_SRC - 1);
    else if (w_ack) r_last <= r_sel;
  end
`else
  // Fixed priority, source 0 highest
  always_comb begin
    w_win = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = SEL_W'(i);
    end
  end
`endif

  // Control/status registers and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gie    <= 1'b0;
      r_mask   <= '0;
      r_pend   <= '0;
      r_done_q <= '0;
    end else begin
      r_gie    <= w_gie_nxt;
      r_mask   <= w_mask_nxt;
      r_pend   <= w_pend_nxt;
      r_done_q <= done;
    end
  end

  // ISR address table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SRC); i++) r_isr[i] <= '0;
    end else if (w_wr_isr) begin
      r_isr[w_idx[1:0]] <= write_data;
    end
  end

  // FSM state register plus its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_irq      <= 1'b0;
      r_isr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_irq      <= w_irq_nxt;
      r_isr_addr <= w_isr_addr_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cand != '0) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_ack || w_cancel) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; isr_addr is captured once and held through cancel
  always_comb begin
    w_irq_nxt      = r_irq;
    w_sel_nxt      = r_sel;
    w_isr_addr_nxt = r_isr_addr;
    case (r_state)
      S_IDLE: begin
        w_irq_nxt = 1'b0;
        if (w_cand != '0) begin
          w_irq_nxt      = 1'b1;
          w_sel_nxt      = w_win;
          w_isr_addr_nxt = r_isr[w_win];
        end
      end
      S_ACTIVE: if (w_ack || w_cancel) w_irq_nxt = 1'b0;
      default:  w_irq_nxt = 1'b0;
    endcase
  end

  assign w_stat_src = (r_state == S_ACTIVE) ? w_sel_oh : '0;

  // Combinational register read
  always_comb begin
    read_data = '0;
    case (w_idx)
      REG_CTRL:                read_data = {31'b0, r_gie};
      REG_MASK:                read_data = {28'b0, r_mask};
      REG_PEND:                read_data = {28'b0, r_pend};
      REG_STAT:                read_data = {23'b0, r_irq, 4'b0, w_stat_src};
      4'h4, 4'h5, 4'h6, 4'h7:  read_data = r_isr[w_idx[1:0]];
      default:                 read_data = '0;
    endcase
  end

  assign IRQ      = r_irq;
  assign isr_addr = r_isr_addr;

endmodule

// File: tb/tb_intc_top_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intc_top_ctrl : scoreboard bench for intc_top_ctrl.
//   Stimulus pushes expected register reads and expected IRQ isr_addr values
//   into queues; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_intc_top_ctrl;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_MASK = 32'h04;
  localparam logic [31:0] A_PEND = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_ISR0 = 32'h10;
  localparam logic [31:0] A_ISR1 = 32'h14;
  localparam logic [31:0] A_ISR2 = 32'h18;
  localparam logic [31:0] A_ISR3 = 32'h1C;

  logic        clk;
  logic        rst_n;
  logic [3:0]  done;
  logic        IACK;
  logic [31:0] input_addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        IRQ;
  logic [31:0] isr_addr;

  intc_top_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .done         (done),
    .IACK         (IACK),
    .input_addr   (input_addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .IRQ          (IRQ),
    .isr_addr     (isr_addr)
  );

  typedef struct {
    logic [31:0] data;
    logic        irq;
    logic        chk_isr;
    logic [31:0] isr;
    string       name;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [31:0] irq_q[$];
  logic        rd_vld;
  logic        all_done;
  logic        irq_prev;
  int          n_checks;
  int          n_errors;
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every presented read and every IRQ rise
  always @(negedge clk) begin
    rd_exp_t e;
    cyc = cyc + 1;
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        n_checks = n_checks + 1; n_errors = n_errors + 1;
        $display("FAIL rd_q_underflow: read presented with no expectation");
      end else begin
        e = rd_q.pop_front();
        n_checks = n_checks + 1;
        if (read_data !== e.data) begin
          n_errors = n_errors + 1;
          $display("FAIL %s read_data: got=%08h exp=%08h", e.name, read_data, e.data);
        end
        n_checks = n_checks + 1;
        if (IRQ !== e.irq) begin
          n_errors = n_errors + 1;
          $display("FAIL %s IRQ: got=%0b exp=%0b", e.name, IRQ, e.irq);
        end
        if (e.chk_isr) begin
          n_checks = n_checks + 1;
          if (isr_addr !== e.isr) begin
            n_errors = n_errors + 1;
            $display("FAIL %s isr_addr: got=%08h exp=%08h", e.name, isr_addr, e.isr);
          end
        end
      end
    end
    if (IRQ === 1'b1 && irq_prev !== 1'b1) begin
      n_checks = n_checks + 1;
      if (irq_q.size() == 0) begin
        n_errors = n_errors + 1;
        $display("FAIL irq_unexpected: isr_addr=%08h exp=none", isr_addr);
      end else begin
        logic [31:0] ex;
        ex = irq_q.pop_front();
        if (isr_addr !== ex) begin
          n_errors = n_errors + 1;
          $display("FAIL irq_isr_addr: got=%08h exp=%08h", isr_addr, ex);
        end
      end
    end
    irq_prev = IRQ;
    if (all_done || cyc > 3000) begin
      if (!all_done) begin
        n_checks = n_checks + 1; n_errors = n_errors + 1;
        $display("FAIL timeout: cycles=%0d exp<=3000", cyc);
      end
      n_checks = n_checks + 1;
      if (irq_q.size() != 0) begin
        n_errors = n_errors + 1;
        $display("FAIL irq_q_leftover: got=%0d exp=0", irq_q.size());
      end
      n_checks = n_checks + 1;
      if (rd_q.size() != 0) begin
        n_errors = n_errors + 1;
        $display("FAIL rd_q_leftover: got=%0d exp=0", rd_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    input_addr = a; write_data = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  // One read check per cycle, sampled by the monitor at the negedge
  task automatic chk_full(input logic [31:0] a, input logic [31:0] d, input logic irq,
                          input logic ci, input logic [31:0] isr, input string name);
    rd_exp_t e;
    e.data = d; e.irq = irq; e.chk_isr = ci; e.isr = isr; e.name = name;
    rd_q.push_back(e);
    input_addr = a; rd_vld = 1'b1;
    @(negedge clk); #1;
    rd_vld = 1'b0;
    tick();
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] d, input logic irq,
                     input string name);
    chk_full(a, d, irq, 1'b0, 32'h0, name);
  endtask

  logic [31:0] first_isr, second_isr, first_stat, second_stat, second_pend;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; irq_prev = 1'b0;
    rd_vld = 1'b0; all_done = 1'b0;
    rst_n = 1'b0; done = 4'h0; IACK = 1'b0;
    input_addr = 32'h0; write_enable = 1'b0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values and basic readback
    chk_full(A_STAT, 32'h0, 1'b0, 1'b1, 32'h0, "rst_stat");
    chk(A_CTRL, 32'h0, 1'b0, "rst_ctrl");
    chk(A_MASK, 32'h0, 1'b0, "rst_mask");
    chk(A_PEND, 32'h0, 1'b0, "rst_pend");
    chk(A_ISR0, 32'h0, 1'b0, "rst_isr0");
    wr(A_ISR2, 32'h0000_4000);
    chk(A_ISR2, 32'h0000_4000, 1'b0, "isr2_rb");
    chk(32'h3C, 32'h0, 1'b0, "unmapped_3c");
    wr(32'h20, 32'hFFFF_FFFF);
    chk(32'h20, 32'h0, 1'b0, "unmapped_20");
    wr(A_CTRL, 32'hFFFF_FFFF);
    chk(A_CTRL, 32'h1, 1'b0, "ctrl_rb");

    // Single interrupt on source 1
    wr(A_MASK, 32'hF);
    wr(A_ISR0, 32'h0000_00A0);
    wr(A_ISR1, 32'h0000_1000);
    wr(A_ISR2, 32'h0000_2000);
    wr(A_ISR3, 32'h0000_3000);
    irq_q.push_back(32'h0000_1000);
    done = 4'b0010;
    chk(A_PEND, 32'h0, 1'b0, "s_pend0");
    done = 4'b0000;
    chk(A_PEND, 32'h2, 1'b0, "s_pend1");
    chk(A_STAT, 32'h102, 1'b1, "s_stat");
    IACK = 1'b1;
    chk(A_STAT, 32'h102, 1'b1, "s_ack");
    IACK = 1'b0;
    chk(A_PEND, 32'h0, 1'b0, "s_retired");

    // Two simultaneous sources
`ifdef INTC_ROUND_ROBIN_EN
    first_isr = 32'h3000; second_isr = 32'h1000;
    first_stat = 32'h108; second_stat = 32'h102; second_pend = 32'h2;
`else
    first_isr = 32'h1000; second_isr = 32'h3000;
    first_stat = 32'h102; second_stat = 32'h108; second_pend = 32'h8;
`endif
    irq_q.push_back(first_isr);
    irq_q.push_back(second_isr);
    done = 4'b1010;
    chk(A_PEND, 32'h0, 1'b0, "p_pend0");
    done = 4'b0000;
    chk(A_PEND, 32'hA, 1'b0, "p_pend1");
    chk(A_STAT, first_stat, 1'b1, "p_first");
    IACK = 1'b1;
    chk(A_STAT, first_stat, 1'b1, "p_ack1");
    IACK = 1'b0;
    chk(A_STAT, 32'h0, 1'b0, "p_gap");
    chk(A_STAT, second_stat, 1'b1, "p_second");
    IACK = 1'b1;
    chk(A_PEND, second_pend, 1'b1, "p_ack2");
    IACK = 1'b0;
    chk(A_PEND, 32'h0, 1'b0, "p_empty");

    // Masked source stays pending, fires once unmasked
    wr(A_MASK, 32'h0);
    done = 4'b0001;
    chk(A_PEND, 32'h0, 1'b0, "m_pend0");
    done = 4'b0000;
    chk(A_PEND, 32'h1, 1'b0, "m_pend1");
    chk(A_STAT, 32'h0, 1'b0, "m_quiet");
    irq_q.push_back(32'h0000_00A0);
    wr(A_MASK, 32'h1);
    chk(A_STAT, 32'h0, 1'b0, "m_arb");
    chk(A_STAT, 32'h101, 1'b1, "m_fire");
    IACK = 1'b1;
    chk(A_STAT, 32'h101, 1'b1, "m_ack");
    IACK = 1'b0;
    chk(A_PEND, 32'h0, 1'b0, "m_retired");
    wr(A_MASK, 32'hF);

    // Software cancel on source 2; held isr_addr ignores later ISR writes
    irq_q.push_back(32'h0000_2000);
    done = 4'b0100;
    chk(A_PEND, 32'h0, 1'b0, "c_pend0");
    done = 4'b0000;
    chk(A_PEND, 32'h4, 1'b0, "c_pend1");
    wr(A_ISR2, 32'h0000_2222);
    chk_full(A_STAT, 32'h104, 1'b1, 1'b1, 32'h0000_2000, "c_held");
    wr(A_PEND, 32'h4);
    chk_full(A_STAT, 32'h0, 1'b0, 1'b1, 32'h0000_2000, "c_cancel");
    chk(A_PEND, 32'h0, 1'b0, "c_pend_clr");

    // New edge collides with IACK of the same source
    irq_q.push_back(32'h0000_00A0);
    irq_q.push_back(32'h0000_00A0);
    done = 4'b0001;
    chk(A_PEND, 32'h0, 1'b0, "k_pend0");
    done = 4'b0000;
    chk(A_PEND, 32'h1, 1'b0, "k_pend1");
    chk(A_STAT, 32'h101, 1'b1, "k_active");
    IACK = 1'b1; done = 4'b0001;
    chk(A_STAT, 32'h101, 1'b1, "k_collide");
    IACK = 1'b0; done = 4'b0000;
    chk(A_PEND, 32'h1, 1'b0, "k_gap");
    chk(A_STAT, 32'h101, 1'b1, "k_refire");
    IACK = 1'b1;
    chk(A_STAT, 32'h101, 1'b1, "k_ack");
    IACK = 1'b0;
    chk(A_PEND, 32'h0, 1'b0, "k_retired");

    // Held-high done does not retrigger
    irq_q.push_back(32'h0000_1000);
    done = 4'b0010;
    chk(A_PEND, 32'h0, 1'b0, "h_pend0");
    chk(A_PEND, 32'h2, 1'b0, "h_pend1");
    chk(A_STAT, 32'h102, 1'b1, "h_active");
    IACK = 1'b1;
    chk(A_STAT, 32'h102, 1'b1, "h_ack");
    IACK = 1'b0;
    chk(A_PEND, 32'h0, 1'b0, "h_noretrig0");
    chk(A_STAT, 32'h0, 1'b0, "h_noretrig1");
    done = 4'b0000;

    // IACK while idle is ignored; GIE drop cancels
    wr(A_MASK, 32'h0);
    done = 4'b1000;
    chk(A_PEND, 32'h0, 1'b0, "g_pend0");
    done = 4'b0000;
    chk(A_PEND, 32'h8, 1'b0, "g_pend1");
    IACK = 1'b1;
    chk(A_PEND, 32'h8, 1'b0, "g_idle_ack");
    IACK = 1'b0;
    chk(A_PEND, 32'h8, 1'b0, "g_still_pend");
    irq_q.push_back(32'h0000_3000);
    wr(A_MASK, 32'hF);
    chk(A_STAT, 32'h0, 1'b0, "g_arb");
    chk(A_STAT, 32'h108, 1'b1, "g_fire");
    wr(A_CTRL, 32'h0);
    chk(A_STAT, 32'h0, 1'b0, "g_cancel");
    chk(A_PEND, 32'h8, 1'b0, "g_pend_kept");

    // Re-enable, then asynchronous reset mid-cycle while active
    irq_q.push_back(32'h0000_3000);
    wr(A_CTRL, 32'h1);
    chk(A_STAT, 32'h0, 1'b0, "r_arb");
    chk(A_STAT, 32'h108, 1'b1, "r_fire");
    #3 rst_n = 1'b0;
    chk_full(A_STAT, 32'h0, 1'b0, 1'b1, 32'h0, "r_stat");
    chk(A_CTRL, 32'h0, 1'b0, "r_ctrl");
    chk(A_MASK, 32'h0, 1'b0, "r_mask");
    chk(A_PEND, 32'h0, 1'b0, "r_pend");
    chk(A_ISR3, 32'h0, 1'b0, "r_isr3");
    rst_n = 1'b1;
    chk(A_STAT, 32'h0, 1'b0, "r_after");

    tick();
    all_done = 1'b1;
  end

endmodule

// File: doc/intc_top_ctrl.md
Name: intc_top_ctrl

Overview:
Four-source memory-mapped interrupt controller. It sits between the accelerator "done" flags and the host processor. It latches rising edges of done[3:0] as pending interrupts and arbitrates among enabled pending sources. It then raises IRQ with the programmed ISR address of the winner and retires that interrupt on IACK.

Parameters:
NUM_SRC, 4, number of interrupt sources; fixed at 4, not re-parameterisable.
ADDR_W, 32, input_addr width; only bits [5:2] are decoded.
DATA_W, 32, register data width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
done  input  4  per-source completion flags; level inputs, edge-detected internally.
IACK  input  1  interrupt acknowledge from host; sampled on clk.
input_addr  input  32  register byte address; word aligned, bits [1:0] ignored.
write_enable  input  1  register write strobe; one write per clk cycle while high.
write_data  input  32  register write data.
read_data  output  32  combinational read of the register at input_addr.
IRQ  output  1  registered interrupt request to host.
isr_addr  output  32  registered ISR address of the active interrupt.

Behaviour:
Interface is one clock (clk) with asynchronous active-low reset (rst_n). Reset clears every register, pending, edge history and state. After reset IRQ=0 and isr_addr=0.

Register map (offset, access, meaning):
- 0x00 CTRL, RW: bit0 = GIE, global enable. Other bits read 0.
- 0x04 MASK, RW: bits[3:0] = per-source enable.
- 0x08 PEND, R/W1C: bits[3:0] = pending. Writing 1 clears the bit; writing 0 has no effect.
- 0x0C STAT, RO: bits[3:0] = one-hot active source; bit8 = IRQ.
- 0x10/0x14/0x18/0x1C ISR0..ISR3, RW: 32-bit ISR address per source.
- Unmapped offsets read 0 and ignore writes.

Read and write behaviour:
- read_data is purely combinational from input_addr.
- A write takes effect at the clk edge on which write_enable=1.

Edge detection:
- done_q registers done.
- pend_set = done & ~done_q.
- A done edge present on cycle N is latched into PEND at edge N+1.

Candidate selection:
- cand = PEND & MASK & {4{GIE}}.
- Fixed priority: source 0 is highest, source 3 is lowest.

State machine:
- IDLE: if cand != 0, at the next edge latch sel = the winning index. Set IRQ=1 and isr_addr = ISR[sel]; go to ACTIVE. IRQ therefore rises 2 cycles after a done edge when already enabled.
- ACTIVE: IRQ stays 1 and isr_addr is held. Later ISR[sel] writes do not change the held isr_addr.
  - If IACK=1: clear PEND[sel], drop IRQ, go to IDLE.
  - If PEND[sel] is cleared by software, or MASK[sel] or GIE drops: cancel, IRQ=0, go to IDLE, isr_addr holds its last value.
- After returning to IDLE, re-arbitration happens no earlier than the following cycle. IRQ is therefore low for at least 1 cycle between interrupts.

Boundary cases:
- A set and a clear of the same PEND bit in the same cycle (from IACK or W1C): set wins and the bit stays pending.
- Multiple simultaneous edges: all are latched; they are served in priority order.
- A held-high done does not retrigger. A new 0→1 transition is required.
- IACK while IDLE is ignored.
- A source whose pending bit is set while masked stays pending. It fires once MASK is set.
- Reset mid-operation: immediate return to the reset state regardless of clk.

Optional Feature:
Macro INTC_ROUND_ROBIN_EN.
- Defined: rotating priority. A 2-bit last-served pointer is updated on each IACK. The search starts at (last+1) mod 4. The pointer resets to 3, so the first search starts at source 0.
- Not defined: fixed priority, 0 highest. The pointer logic is absent.
- The register map is identical in both builds.

Test Plan:
1. Reset/readback: assert rst_n=0 mid-cycle → IRQ=0, isr_addr=0, all registers read 0. Write ISR2=0x0000_4000 → reading 0x18 returns 0x0000_4000. Reading 0x3C returns 0.
2. Single interrupt: set GIE=1, MASK=0xF, ISR1=0x1000, then pulse done[1] → IRQ=1 two cycles later, isr_addr=0x1000, STAT=0x102. Pulse IACK → IRQ=0 next cycle, PEND=0.
3. Priority: done=0b1010 in one cycle with ISR1=0x1000, ISR3=0x3000 → first isr_addr=0x1000. After IACK, IRQ is low for 1 cycle, then isr_addr=0x3000. Under INTC_ROUND_ROBIN_EN, with last-served=1, the order is 3 then 1.
4. Masking: MASK=0x0, pulse done[0] → PEND=0x1, IRQ stays 0. Write MASK=0x1 → IRQ=1 within 2 cycles.
5. Cancel: while ACTIVE on source 2, write PEND=0x4 → IRQ=0 next cycle and STAT bit8=0.
6. Collision: a new done[0] edge on the same cycle as IACK for active source 0 → PEND[0] stays 1 and IRQ re-asserts after the 1-cycle gap.
